// File: rtl/fifo_frame_pkg.sv
// Shared definitions for the FIFO drain / UART framing scheduler.
package fifo_frame_pkg;

  typedef logic [2:0] state_t;

  localparam state_t StIdle = 3'd0;
  localparam state_t StSync = 3'd1;
  localparam state_t StLen  = 3'd2;
  localparam state_t StData = 3'd3;
  localparam state_t StCsum = 3'd4;

  // Sync, length and checksum bytes wrapped around every payload.
  localparam int unsigned FRAME_OVERHEAD = 3;

  localparam logic [7:0] DEFAULT_SYNC_BYTE = 8'hA5;

endpackage

// File: rtl/frame_timeout_timer.sv
// Saturating idle timer: expired is high once the count reaches TIMEOUT-1.
module frame_timeout_timer #(
  parameter int unsigned TIMEOUT = 1200000,
  localparam int unsigned TW     = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic count_en,
  output logic expired
);

  localparam logic [TW-1:0] Last = TW'(TIMEOUT - 1);

  logic [TW-1:0] cnt_q, cnt_d;

  assign expired = (cnt_q == Last);

  always_comb begin
    cnt_d = cnt_q;
    if (clear) begin
      cnt_d = '0;
    end else if (count_en && !expired) begin
      cnt_d = cnt_q + TW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/fifo_frame_scheduler.sv
// Drains a FWFT FIFO into framed UART packets: sync, length, payload, XOR checksum.
module fifo_frame_scheduler
  import fifo_frame_pkg::*;
#(
  parameter int unsigned MAX_BURST   = 64,
  parameter int unsigned TIMEOUT     = 1200000,
  parameter logic [7:0]  SYNC_BYTE   = DEFAULT_SYNC_BYTE,
  parameter int unsigned LEVEL_WIDTH = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   enable,
  output logic                   fifo_rd_en,
  input  logic [7:0]             fifo_rd_DATA,
  input  logic                   fifo_empty,
  input  logic [LEVEL_WIDTH-1:0] fifo_level,
  output logic                   tx_dv,
  output logic [7:0]             tx_DATA,
  input  logic                   tx_ready,
  output logic                   busy,
  output logic                   frame_done
);

  state_t     state_q, state_d;
  logic [7:0] len_q, len_d;
  logic [7:0] cnt_q, cnt_d;
  logic [7:0] csum_q, csum_d;
  logic       done_q, done_d;

  logic       level_nz, burst_hit, expired, trigger, accept;
  logic [7:0] n_trig;

  assign level_nz  = |fifo_level;
  assign burst_hit = 32'(fifo_level) >= MAX_BURST;
  // Below a full burst the level is < MAX_BURST <= 255, so truncation is safe.
  assign n_trig    = burst_hit ? 8'(MAX_BURST) : 8'(fifo_level);
  assign trigger   = (state_q == StIdle) && enable && (burst_hit || (level_nz && expired));
  assign accept    = tx_dv && tx_ready;

  frame_timeout_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .clear    (!level_nz || trigger),
    .count_en ((state_q == StIdle) && level_nz),
    .expired  (expired)
  );

  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    cnt_d   = cnt_q;
    csum_d  = csum_q;
    done_d  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (trigger) begin
          len_d   = n_trig;
          csum_d  = n_trig;
          state_d = StSync;
        end
      end
      StSync: if (tx_ready) state_d = StLen;
      StLen: begin
        if (tx_ready) begin
          cnt_d   = len_q;
          state_d = StData;
        end
      end
      StData: begin
        if (accept) begin
          csum_d = csum_q ^ fifo_rd_DATA;
          cnt_d  = cnt_q - 8'd1;
          if (cnt_q == 8'd1) state_d = StCsum;
        end
      end
      StCsum: begin
        if (tx_ready) begin
          done_d  = 1'b1;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      len_q   <= '0;
      cnt_q   <= '0;
      csum_q  <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      cnt_q   <= cnt_d;
      csum_q  <= csum_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    tx_DATA = 8'h00;
    unique case (state_q)
      StSync:  tx_DATA = SYNC_BYTE;
      StLen:   tx_DATA = len_q;
      StData:  tx_DATA = fifo_rd_DATA;
      StCsum:  tx_DATA = csum_q;
      default: tx_DATA = 8'h00;
    endcase
  end

  assign tx_dv      = (state_q != StIdle);
  assign busy       = tx_dv;
  assign frame_done = done_q;
  // An empty FIFO here is an integration error; never pop it.
  assign fifo_rd_en = (state_q == StData) && tx_ready && !fifo_empty;

endmodule

// File: tb/tb_fifo_frame_scheduler.sv
// Directed bench for fifo_frame_scheduler with a behavioural FWFT FIFO in front of it.
module tb_fifo_frame_scheduler;

  localparam int unsigned LW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          enable;
  logic          fifo_rd_en;
  logic [7:0]    fifo_rd_DATA;
  logic          fifo_empty;
  logic [LW-1:0] fifo_level;
  logic          tx_dv;
  logic [7:0]    tx_DATA;
  logic          tx_ready;
  logic          busy;
  logic          frame_done;

  fifo_frame_scheduler #(
    .MAX_BURST   (4),
    .TIMEOUT     (16),
    .SYNC_BYTE   (8'hA5),
    .LEVEL_WIDTH (LW)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .enable       (enable),
    .fifo_rd_en   (fifo_rd_en),
    .fifo_rd_DATA (fifo_rd_DATA),
    .fifo_empty   (fifo_empty),
    .fifo_level   (fifo_level),
    .tx_dv        (tx_dv),
    .tx_DATA      (tx_DATA),
    .tx_ready     (tx_ready),
    .busy         (busy),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  // FWFT FIFO model; pops are decided on the negedge before the popping edge.
  logic [7:0] mem [0:255];
  logic [7:0] wp = 8'd0;
  logic [7:0] rp = 8'd0;
  logic       pop_pend = 1'b0;

  assign fifo_level   = LW'(8'(wp - rp));
  assign fifo_empty   = (wp == rp);
  assign fifo_rd_DATA = mem[rp];

  initial begin
    forever begin
      @(negedge clk);
      pop_pend = fifo_rd_en && !rst;
      @(posedge clk);
      if (pop_pend) rp <= rp + 8'd1;
    end
  end

  // Beat monitor plus handshake rule tracking.
  logic [7:0] beats[$];
  int         beat_cyc[$];
  logic [7:0] exp_q[$];
  int         cyc = 0;
  int         rd_cnt = 0;
  int         bad_rd = 0;
  int         stall_err = 0;
  logic       prev_stall = 1'b0;
  logic [7:0] prev_data = 8'h00;

  initial begin
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall && tx_dv && tx_DATA !== prev_data) stall_err++;
        prev_stall = tx_dv && !tx_ready;
        prev_data  = tx_DATA;
        if (tx_dv && tx_ready) begin
          beats.push_back(tx_DATA);
          beat_cyc.push_back(cyc);
        end
        if (fifo_rd_en) begin
          rd_cnt++;
          if (!(tx_dv && tx_ready && dut.state_q == 3'd3)) bad_rd++;
        end
      end
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    mem[wp] = b;
    wp      = wp + 8'd1;
  endtask

  task automatic wait_done(input string tag, input bit rnd);
    bit seen = 1'b0;
    for (int k = 0; k < 300 && !seen; k++) begin
      @(posedge clk);
      #1;
      if (rnd) tx_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      if (frame_done) seen = 1'b1;
    end
    tx_ready = 1'b1;
    check_eq({tag, "_done"}, 32'(seen), 32'd1);
  endtask

  task automatic check_frame(input string tag);
    logic [7:0] g;
    check_eq({tag, "_nbytes"}, 32'(beats.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) begin
      g = (i < beats.size()) ? beats[i] : 8'hxx;
      check_eq($sformatf("%s_b%0d", tag, i), 32'(g), 32'(exp_q[i]));
    end
  endtask

  // Counts idle negedges until tx_dv rises, starting from a given count.
  task automatic count_idle(input int start, output int n);
    n = start;
    for (int k = 0; k < 100 && !tx_dv; k++) begin
      @(negedge clk);
      if (!tx_dv) n++;
    end
  endtask

  task automatic count_dv(input int ncyc, output int n);
    n = 0;
    for (int k = 0; k < ncyc; k++) begin
      @(negedge clk);
      if (tx_dv) n++;
    end
  endtask

  initial begin
    int n;
    int rd0;
    rst      = 1'b1;
    enable   = 1'b1;
    tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_tx_dv", 32'(tx_dv), 32'd0);
    check_eq("rst_tx_data", 32'(tx_DATA), 32'd0);
    check_eq("rst_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rst_busy", 32'(busy), 32'd0);
    check_eq("rst_done", 32'(frame_done), 32'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // Full burst: 7 consecutive beats, then a single-cycle frame_done.
    beats.delete(); beat_cyc.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_done("burst", 1'b0);
    exp_q = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    check_frame("burst");
    check_eq("burst_span", 32'(beat_cyc.size() == 7 ? beat_cyc[6] - beat_cyc[0] : -1), 32'd6);
    check_eq("burst_empty", 32'(fifo_empty), 32'd1);
    @(negedge clk);
    check_eq("burst_done_pulse", 32'(frame_done), 32'd0);

    // Timeout frame for a single residual byte.
    @(posedge clk);
    #1;
    beats.delete();
    push(8'h5A);
    count_idle(0, n);
    check_eq("tmo_idle", 32'(n), 32'd16);
    wait_done("tmo", 1'b0);
    exp_q = '{8'hA5, 8'h01, 8'h5A, 8'h5B};
    check_frame("tmo");

    // Split burst: full frame now, remainder after the timeout.
    @(posedge clk);
    #1;
    beats.delete();
    for (int i = 1; i <= 6; i++) push(8'(i));
    wait_done("split1", 1'b0);
    exp_q = '{8'hA5, 8'h04, 8'h01, 8'h02, 8'h03, 8'h04, 8'h00};
    check_frame("split1");
    beats.delete();
    count_idle(1, n);
    check_eq("split_idle", 32'(n), 32'd16);
    wait_done("split2", 1'b0);
    exp_q = '{8'hA5, 8'h02, 8'h05, 8'h06, 8'h01};
    check_frame("split2");

    // Random backpressure on the full-burst stimulus.
    @(posedge clk);
    #1;
    beats.delete();
    rd0       = rd_cnt;
    stall_err = 0;
    bad_rd    = 0;
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    wait_done("bp", 1'b1);
    exp_q = '{8'hA5, 8'h04, 8'h11, 8'h22, 8'h33, 8'h44, 8'h40};
    check_frame("bp");
    check_eq("bp_stall_stable", 32'(stall_err), 32'd0);
    check_eq("bp_rd_pulses", 32'(rd_cnt - rd0), 32'd4);
    check_eq("bp_rd_coincide", 32'(bad_rd), 32'd0);

    // Reset after two payload bytes; the rest drains by timeout.
    @(posedge clk);
    #1;
    beats.delete();
    push(8'h11); push(8'h22); push(8'h33); push(8'h44);
    for (int k = 0; k < 50 && beats.size() < 4; k++) @(negedge clk);
    check_eq("rstmid_reached", 32'(beats.size()), 32'd4);
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    check_eq("rstmid_tx_dv", 32'(tx_dv), 32'd0);
    check_eq("rstmid_rd_en", 32'(fifo_rd_en), 32'd0);
    check_eq("rstmid_busy", 32'(busy), 32'd0);
    check_eq("rstmid_level", 32'(fifo_level), 32'd2);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    beats.delete();
    wait_done("rstmid", 1'b0);
    exp_q = '{8'hA5, 8'h02, 8'h33, 8'h44, 8'h75};
    check_frame("rstmid");

    // Enable gating, and a frame that completes after enable drops in LEN.
    @(posedge clk);
    #1;
    enable = 1'b0;
    for (int i = 0; i < 10; i++) push(8'(8'h10 + i));
    count_dv(40, n);
    check_eq("en_off_nodv", 32'(n), 32'd0);
    beats.delete();
    @(posedge clk);
    #1;
    enable = 1'b1;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check_eq("en_in_len", 32'(tx_DATA), 32'h04);
    enable = 1'b0;
    wait_done("en", 1'b0);
    exp_q = '{8'hA5, 8'h04, 8'h10, 8'h11, 8'h12, 8'h13, 8'h04};
    check_frame("en");
    count_dv(40, n);
    check_eq("en_after_nodv", 32'(n), 32'd0);
    check_eq("en_level", 32'(fifo_level), 32'd6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
